// File: rtl/alu_rr_arbiter_pkg.sv
// Shared constants for the round-robin ALU arbiter slice.
//   - opcode encodings (OP_ADD..OP_XNOR, OP_ILL)
//   - bit positions inside the 4-bit {NEG,POS,ZERO,OVF} flag word
//   - response-slot FSM state encodings
package alu_rr_arbiter_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SHF  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    localparam int FLG_NEG  = 3;
    localparam int FLG_POS  = 2;
    localparam int FLG_ZERO = 1;
    localparam int FLG_OVF  = 0;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/alu10_core.sv
// Purely combinational signed ALU.
// Ports:
//   arg0, arg1 : W-bit two's-complement operands
//   oper       : opcode (see alu_rr_arbiter_pkg)
//   result     : W-bit truncated result
//   flag       : {NEG,POS,ZERO,OVF} derived from the truncated result
//   err        : opcode 7 (illegal); result forced to 0
module alu10_core
    import alu_rr_arbiter_pkg::*;
#(
    parameter int W = 10
) (
    input  logic signed [W-1:0] arg0,
    input  logic signed [W-1:0] arg1,
    input  logic [2:0]          oper,
    output logic signed [W-1:0] result,
    output logic [3:0]          flag,
    output logic                err
);

    localparam logic [W:0] LIM = (W+1)'(W);

    logic [W:0]   bx;
    logic [W:0]   mag;
    logic [W-1:0] shf;
    logic         a_pos, a_neg, b_pos, b_neg, r_neg, r_zero, ovf;

    // Shift distance is |arg1|; one extra bit so -(-2^(W-1)) is representable.
    assign bx  = {arg1[W-1], arg1};
    assign mag = arg1[W-1] ? (~bx + 1'b1) : bx;

    always_comb begin
        shf = '0;
        if (mag < LIM) begin
            if (arg1[W-1]) shf = arg0 >> mag;   // logical: vacated bits are 0
            else           shf = arg0 << mag;
        end
    end

    assign a_neg = arg0[W-1];
    assign b_neg = arg1[W-1];
    assign a_pos = !arg0[W-1] && (arg0 != '0);
    assign b_pos = !arg1[W-1] && (arg1 != '0);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (oper)
            OP_ADD:  result = arg0 + arg1;
            OP_SUB:  result = arg0 - arg1;
            OP_SHF:  result = shf;
            OP_AND:  result = arg0 & arg1;
            OP_OR:   result = arg0 | arg1;
            OP_XOR:  result = arg0 ^ arg1;
            OP_XNOR: result = ~(arg0 ^ arg1);
            default: err    = 1'b1;
        endcase
    end

    assign r_neg  = result[W-1];
    assign r_zero = (result == '0);

    always_comb begin
        ovf = 1'b0;
        case (oper)
            OP_ADD:  ovf = (a_pos && b_pos && r_neg) ||
                           (a_neg && b_neg && !r_neg && !r_zero);
            OP_SUB:  ovf = (a_pos && b_neg && r_neg) ||
                           (a_neg && b_pos && !r_neg && !r_zero);
            default: ovf = 1'b0;
        endcase
    end

    always_comb begin
        flag           = '0;
        flag[FLG_NEG]  = r_neg;
        flag[FLG_POS]  = !r_neg && !r_zero;
        flag[FLG_ZERO] = r_zero;
        flag[FLG_OVF]  = ovf;
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared signed ALU.
// An accepted operation is computed in its accept cycle and captured in a
// single-entry response register; the slot can drain and refill in one cycle.
// Ports:
//   i_clk, i_rst                      : clock, async active-high reset
//   i_reqN_valid/arg0/arg1/oper       : requester N operation (N = 0,1)
//   o_reqN_ready                      : requester N accepted this cycle
//   o_rsp_valid/id/result/flag/err    : held response, source id, status
//   i_rsp_ready                       : consumer takes the response
//   o_cnt0, o_cnt1                    : responses delivered per requester
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int W     = 10,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic [W-1:0]     i_req0_arg0,
    input  logic [W-1:0]     i_req0_arg1,
    input  logic [2:0]       i_req0_oper,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [W-1:0]     i_req1_arg0,
    input  logic [W-1:0]     i_req1_arg1,
    input  logic [2:0]       i_req1_oper,
    output logic             o_req1_ready,
    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic [W-1:0]     o_rsp_result,
    output logic [3:0]       o_rsp_flag,
    output logic             o_rsp_err,
    input  logic             i_rsp_ready,
    output logic [CNT_W-1:0] o_cnt0,
    output logic [CNT_W-1:0] o_cnt1
);

    logic [1:0]          valid;
    logic [1:0][W-1:0]   a0, a1;
    logic [1:0][2:0]     op;
    logic [1:0]          ready;
    logic [0:0]          state;
    logic                last;
    logic                gid;
    logic                free;
    logic                accept;
    logic                deliver;
    logic [W-1:0]        alu_res;
    logic [3:0]          alu_flag;
    logic                alu_err;
    logic [CNT_W-1:0]    cnt [2];

    assign valid = {i_req1_valid, i_req0_valid};
    assign a0    = {i_req1_arg0, i_req0_arg0};
    assign a1    = {i_req1_arg1, i_req0_arg1};
    assign op    = {i_req1_oper, i_req0_oper};

    assign o_rsp_valid = (state == ST_FULL);
    assign free        = (state == ST_EMPTY) || i_rsp_ready;
    assign deliver     = o_rsp_valid && i_rsp_ready;

    // Contention goes to whoever was not served last; otherwise the lone requester.
    assign gid    = (valid == 2'b11) ? ~last : valid[1];
    assign accept = free && (valid != 2'b00);

    always_comb begin
        ready      = '0;
        ready[gid] = accept;
    end

    assign o_req0_ready = ready[0];
    assign o_req1_ready = ready[1];

    alu10_core #(.W(W)) u_alu (
        .arg0   (a0[gid]),
        .arg1   (a1[gid]),
        .oper   (op[gid]),
        .result (alu_res),
        .flag   (alu_flag),
        .err    (alu_err)
    );

    // Data fields only load on accept, so they hold after the slot drains.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_EMPTY;
            last         <= 1'b1;
            o_rsp_id     <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_flag   <= '0;
            o_rsp_err    <= 1'b0;
        end else if (accept) begin
            state        <= ST_FULL;
            last         <= gid;
            o_rsp_id     <= gid;
            o_rsp_result <= alu_res;
            o_rsp_flag   <= alu_flag;
            o_rsp_err    <= alu_err;
        end else if (deliver) begin
            state        <= ST_EMPTY;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_cnt
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                cnt[g] <= '0;
            else if (deliver && (o_rsp_id == 1'(g)))
                cnt[g] <= cnt[g] + 1'b1;
        end
    end

    assign o_cnt0 = cnt[0];
    assign o_cnt1 = cnt[1];

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter.
module tb_alu_rr_arbiter;
    import alu_rr_arbiter_pkg::*;

    localparam int W     = 10;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [W-1:0]     req0_arg0, req0_arg1, req1_arg0, req1_arg1;
    logic [2:0]       req0_oper, req1_oper;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_id, rsp_err, rsp_ready;
    logic [W-1:0]     rsp_result;
    logic [3:0]       rsp_flag;
    logic [CNT_W-1:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .i_req0_arg0  (req0_arg0),
        .i_req0_arg1  (req0_arg1),
        .i_req0_oper  (req0_oper),
        .o_req0_ready (req0_ready),
        .i_req1_valid (req1_valid),
        .i_req1_arg0  (req1_arg0),
        .i_req1_arg1  (req1_arg1),
        .i_req1_oper  (req1_oper),
        .o_req1_ready (req1_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .o_rsp_flag   (rsp_flag),
        .o_rsp_err    (rsp_err),
        .i_rsp_ready  (rsp_ready),
        .o_cnt0       (cnt0),
        .o_cnt1       (cnt1)
    );

    // Overflow vectors (req0 only)
    logic signed [W-1:0] ov_a   [3] = '{10'sd300, -10'sd300, 10'sd5};
    logic signed [W-1:0] ov_b   [3] = '{10'sd300, 10'sd300, 10'sd5};
    logic [2:0]          ov_op  [3] = '{OP_ADD, OP_SUB, OP_SUB};
    logic signed [W-1:0] ov_res [3] = '{-10'sd424, 10'sd424, 10'sd0};
    logic [3:0]          ov_flg [3] = '{4'b1001, 4'b0101, 4'b0010};

    // Edge-case vectors (req0 only)
    logic signed [W-1:0] ed_a   [4] = '{10'sd3, 10'sd1, 10'sd0, 10'sd5};
    logic signed [W-1:0] ed_b   [4] = '{-10'sd1, 10'sd12, 10'sd0, 10'sd5};
    logic [2:0]          ed_op  [4] = '{OP_SHF, OP_SHF, OP_XNOR, OP_ILL};
    logic signed [W-1:0] ed_res [4] = '{10'sd1, 10'sd0, -10'sd1, 10'sd0};
    logic [3:0]          ed_flg [4] = '{4'b0100, 4'b0010, 4'b1000, 4'b0010};
    logic                ed_err [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    task automatic set_req(input int n, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] op);
        if (n == 0) begin
            req0_valid = v; req0_arg0 = a; req0_arg1 = b; req0_oper = op;
        end else begin
            req1_valid = v; req1_arg0 = a; req1_arg1 = b; req1_oper = op;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        set_req(0, 1'b0, '0, '0, OP_ADD);
        set_req(1, 1'b0, '0, '0, OP_ADD);
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_req(0, 1'b0, '0, '0, OP_ADD);
        set_req(1, 1'b0, '0, '0, OP_ADD);
        rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", rsp_result); end
        n_cmp++; if ({rsp_id, rsp_err, rsp_flag} !== 6'b0) begin n_bad++; $display("FAIL reset_id_err_flag: got %b want 0", {rsp_id, rsp_err, rsp_flag}); end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
        n_cmp++; if ({cnt0, cnt1} !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add;
        set_req(0, 1'b1, 10'd100, 10'd50, OP_ADD);
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL add_ready: got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, OP_ADD);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 1'b0) begin n_bad++; $display("FAIL add_id: got %b want 0", rsp_id); end
        n_cmp++; if (rsp_result !== 10'sd150) begin n_bad++; $display("FAIL add_result: got %0d want 150", $signed(rsp_result)); end
        n_cmp++; if ({rsp_flag, rsp_err} !== 5'b0100_0) begin n_bad++; $display("FAIL add_flag: got %b/%b want 0100/0", rsp_flag, rsp_err); end
        @(negedge clk);
        n_cmp++; if (cnt0 !== 16'd1) begin n_bad++; $display("FAIL add_cnt0: got %0d want 1", cnt0); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin;
        logic e;
        logic prev;
        do_reset;
        prev = 1'b0;
        set_req(0, 1'b1, 10'd1, 10'd1, OP_ADD);
        set_req(1, 1'b1, 10'd10, 10'd10, OP_ADD);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = (k % 2) == 1;
            #1;
            n_cmp++; if ({req1_ready, req0_ready} !== {e, ~e}) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", k, {req1_ready, req0_ready}, {e, ~e}); end
            if (k > 0) begin
                n_cmp++; if (rsp_id !== prev || rsp_result !== (prev ? 10'd20 : 10'd2)) begin n_bad++; $display("FAIL rr_rsp%0d: got id %b res %0d want id %b", k, rsp_id, rsp_result, prev); end
            end
            prev = e;
            @(negedge clk);
        end
        set_req(0, 1'b0, '0, '0, OP_ADD);
        set_req(1, 1'b0, '0, '0, OP_ADD);
        n_cmp++; if (rsp_id !== 1'b1 || rsp_result !== 10'd20) begin n_bad++; $display("FAIL rr_last: got id %b res %0d want 1/20", rsp_id, rsp_result); end
        n_cmp++; if (cnt0 !== 16'd2 || cnt1 !== 16'd1) begin n_bad++; $display("FAIL rr_cnt_mid: got %0d/%0d want 2/1", cnt0, cnt1); end
        @(negedge clk);
        n_cmp++; if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin n_bad++; $display("FAIL rr_cnt: got %0d/%0d want 2/2", cnt0, cnt1); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rr_empty: got %b want 0", rsp_valid); end
    endtask

    task automatic test_overflow;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, ov_a[i], ov_b[i], ov_op[i]);
            @(negedge clk);
            n_cmp++; if (rsp_result !== ov_res[i]) begin n_bad++; $display("FAIL ovf_result%0d: got %0d want %0d", i, $signed(rsp_result), ov_res[i]); end
            n_cmp++; if (rsp_flag !== ov_flg[i] || rsp_err !== 1'b0) begin n_bad++; $display("FAIL ovf_flag%0d: got %b/%b want %b/0", i, rsp_flag, rsp_err, ov_flg[i]); end
        end
        set_req(0, 1'b0, '0, '0, OP_ADD);
        @(negedge clk);
    endtask

    task automatic test_edge_ops;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, ed_a[i], ed_b[i], ed_op[i]);
            @(negedge clk);
            n_cmp++; if (rsp_result !== ed_res[i]) begin n_bad++; $display("FAIL edge_result%0d: got %0d want %0d", i, $signed(rsp_result), ed_res[i]); end
            n_cmp++; if (rsp_flag !== ed_flg[i] || rsp_err !== ed_err[i]) begin n_bad++; $display("FAIL edge_flag%0d: got %b/%b want %b/%b", i, rsp_flag, rsp_err, ed_flg[i], ed_err[i]); end
        end
        set_req(0, 1'b0, '0, '0, OP_ADD);
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        do_reset;
        set_req(0, 1'b1, 10'd7, 10'd8, OP_ADD);
        set_req(1, 1'b1, 10'd7, 10'd8, OP_SUB);
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_first: got %b want 01", {req1_ready, req0_ready}); end
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 00", c, {req1_ready, req0_ready}); end
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 10'd15) begin n_bad++; $display("FAIL bp_hold%0d: got v%b id%b res %0d want 1/0/15", c, rsp_valid, rsp_id, rsp_result); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_release: got %b want 10", {req1_ready, req0_ready}); end
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, OP_ADD);
        set_req(1, 1'b0, '0, '0, OP_ADD);
        n_cmp++; if (rsp_id !== 1'b1 || rsp_result !== -10'sd1 || rsp_flag !== 4'b1000) begin n_bad++; $display("FAIL bp_next: got id%b res %0d flag %b want 1/-1/1000", rsp_id, $signed(rsp_result), rsp_flag); end
        n_cmp++; if (cnt0 !== 16'd1) begin n_bad++; $display("FAIL bp_cnt0: got %0d want 1", cnt0); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        set_req(0, 1'b1, 10'd2, 10'd3, OP_ADD);
        rsp_ready = 1'b0;
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, OP_ADD);
        n_cmp++; if (rsp_valid !== 1'b1 || cnt0 !== 16'd1 || cnt1 !== 16'd1) begin n_bad++; $display("FAIL rm_pre: got v%b cnt %0d/%0d want 1 1/1", rsp_valid, cnt0, cnt1); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (cnt0 !== '0 || cnt1 !== '0) begin n_bad++; $display("FAIL rm_cnt: got %0d/%0d want 0/0", cnt0, cnt1); end
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 10'd1, 10'd1, OP_OR);
        set_req(1, 1'b1, 10'd1, 10'd1, OP_OR);
        #1;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL rm_ptr: got %b want 01", {req1_ready, req0_ready}); end
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, OP_ADD);
        set_req(1, 1'b0, '0, '0, OP_ADD);
        n_cmp++; if (rsp_id !== 1'b0 || rsp_result !== 10'd1) begin n_bad++; $display("FAIL rm_rsp: got id%b res %0d want 0/1", rsp_id, rsp_result); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_round_robin;
        test_overflow;
        test_edge_ops;
        test_backpressure;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
